instr_assembler: RTL

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

---
 rtl/instr_asm_pkg.sv | 39 +++
 rtl/instr_encode.sv | 60 ++++++
 rtl/instr_assembler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/instr_asm_pkg.sv
// Shared definitions for the instruction assembler: format codes, FSM states,
// the canonical NOP word, RV32I major opcodes and an immediate range helper.
package instr_asm_pkg;

  typedef enum logic [2:0] {
    fmt_r = 3'd0,
    fmt_i = 3'd1,
    fmt_s = 3'd2,
    fmt_b = 3'd3,
    fmt_u = 3'd4,
    fmt_j = 3'd5
  } fmt_t;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_write = 2'd1,
    st_halt  = 2'd2
  } state_t;

  localparam logic [31:0] nop_word = 32'h0000_0013;

  localparam logic [6:0] op_lui    = 7'h37;
  localparam logic [6:0] op_auipc  = 7'h17;
  localparam logic [6:0] op_jal    = 7'h6f;
  localparam logic [6:0] op_jalr   = 7'h67;
  localparam logic [6:0] op_branch = 7'h63;
  localparam logic [6:0] op_load   = 7'h03;
  localparam logic [6:0] op_store  = 7'h23;
  localparam logic [6:0] op_imm    = 7'h13;
  localparam logic [6:0] op_reg    = 7'h33;

  // True when v is representable as a two's-complement value of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] t;
    t = $signed(v) >>> (bits - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I field packer. 'ok' is low for an invalid format code
// and, when INSTR_ASM_IMM_CHECK_EN is defined, for an out-of-range immediate.
module instr_encode
  import instr_asm_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        ok
);

  logic fmt_ok;
  logic imm_ok;

  // Pack fields per instruction format; immediates are truncated to their slots.
  always_comb begin
    word   = nop_word;
    fmt_ok = 1'b1;
    unique case (fmt)
      fmt_r:   word = {funct7, rs2, rs1, funct3, rd, op};
      fmt_i:   word = {imm[11:0], rs1, funct3, rd, op};
      fmt_s:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      fmt_b:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      fmt_u:   word = {imm[31:12], rd, op};
      fmt_j:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef INSTR_ASM_IMM_CHECK_EN
  // Reject immediates that would not survive truncation into their format.
  always_comb begin
    imm_ok = 1'b1;
    unique case (fmt)
      fmt_i, fmt_s: imm_ok = fits_signed(imm, 12);
      fmt_b:        imm_ok = fits_signed(imm, 13) && !imm[0];
      fmt_j:        imm_ok = fits_signed(imm, 21) && !imm[0];
      fmt_u:        imm_ok = (imm[11:0] == 12'h000);
      default:      imm_ok = 1'b1;
    endcase
  end
`else
  // Immediates are truncated silently; only the format code can be rejected.
  always_comb begin
    imm_ok = 1'b1;
  end
`endif

  // Combined acceptance verdict for the bundle.
  always_comb begin
    ok = fmt_ok && imm_ok;
  end

endmodule

// File: rtl/instr_assembler.sv
// Instruction assembler: encodes field bundles, queues them in a small FIFO
// and streams them into instruction memory at consecutive word addresses,
// halting once the memory is full. Optional immediate range checking is
// enabled by defining INSTR_ASM_IMM_CHECK_EN.
module instr_assembler
  import instr_asm_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    fmt,
  input  logic [6:0]                    op,
  input  logic [4:0]                    rd,
  input  logic [2:0]                    funct3,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  input  logic [6:0]                    funct7,
  input  logic [31:0]                   imm,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ready,
  output logic [$clog2(IMEM_WORDS):0]   wr_count,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned ptr_w = $clog2(DEPTH);
  localparam int unsigned cnt_w = ptr_w + 1;
  localparam int unsigned wcw   = $clog2(IMEM_WORDS) + 1;

  logic [31:0]      fifo_mem [DEPTH];
  logic [ptr_w-1:0] rd_ptr_q, wr_ptr_q;
  logic [cnt_w-1:0] count_q;
  logic [wcw-1:0]   wr_count_q;
  logic             err_q;
  state_t           state_q, state_d;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        fifo_full;
  logic        accept, push, pop, last_word;

  instr_encode u_enc (
    .fmt    (fmt),
    .op     (op),
    .rd     (rd),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct7 (funct7),
    .imm    (imm),
    .word   (enc_word),
    .ok     (enc_ok)
  );

  // Handshake, FIFO control and memory-side outputs.
  always_comb begin
    fifo_full = (count_q == cnt_w'(DEPTH));
    in_ready  = !fifo_full && (state_q != st_halt);
    accept    = in_valid && in_ready;
    push      = accept && enc_ok;
    mem_we    = (state_q == st_write);
    pop       = mem_we && mem_ready;
    last_word = (wr_count_q == wcw'(IMEM_WORDS - 1));
    mem_wdata = mem_we ? fifo_mem[rd_ptr_q] : 32'h0;
    mem_addr  = BASE_ADDR + (32'(wr_count_q) << 2);
    wr_count  = wr_count_q;
    done      = (state_q == st_halt);
    err       = err_q;
  end

  // Next-state logic: write while words are queued, halt after the last slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      st_idle: begin
        if (push) state_d = st_write;
      end
      st_write: begin
        if (pop) begin
          if (last_word) begin
            state_d = st_halt;
          end else if (count_q == cnt_w'(1) && !push) begin
            state_d = st_idle;
          end
        end
      end
      st_halt: state_d = st_halt;
      default: state_d = st_idle;
    endcase
  end

  // State, counters and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= st_idle;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !enc_ok;
      if (pop) wr_count_q <= wr_count_q + wcw'(1);
    end
  end

  // FIFO pointers; contents are discarded on entering or sitting in halt.
  always_ff @(posedge clk) begin
    if (reset || state_q == st_halt || (pop && last_word)) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_w'(1);
      if (push && !pop) begin
        count_q <= count_q + cnt_w'(1);
      end else if (!push && pop) begin
        count_q <= count_q - cnt_w'(1);
      end
    end
  end

  // FIFO storage; no reset needed since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= enc_word;
  end

endmodule
